// File: rtl/lsu_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_unit : load/store unit driving a word-wide req/gnt/rvalid memory port.   |
// | Optional LSU_MISALIGN_TRAP_EN: misaligned H/W accesses skip memory and flag  |
// | Misaligned together with Done.                                               |
// | Revision : 1.0                                                               |
// +----------------------------------------------------------------------------+
module lsu_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int FUNCT3_LENGTH = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    input  logic [FUNCT3_LENGTH-1:0] Funct3,
    input  logic [DATA_WIDTH-1:0]    ALUResult,
    input  logic [DATA_WIDTH-1:0]    WriteData,
    output logic [DATA_WIDTH-1:0]    ReadData,
    output logic                     Done,
    output logic                     Stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [DATA_WIDTH-1:0]    mem_addr,
    output logic [3:0]               mem_be,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic                     Misaligned
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e                   state_q;
    logic [FUNCT3_LENGTH-1:0] funct3_q;
    logic [1:0]               offset_q;
    logic [DATA_WIDTH-1:0]    read_data_q;
    logic                     done_q;
    logic                     mem_req_q;
    logic                     mem_we_q;
    logic [DATA_WIDTH-1:0]    mem_addr_q;
    logic [3:0]               mem_be_q;
    logic [DATA_WIDTH-1:0]    mem_wdata_q;

    logic                     req_valid;
    logic                     req_store;
    logic                     req_supported;
    logic                     req_misaligned;
    logic [3:0]               req_be;
    logic [DATA_WIDTH-1:0]    req_wdata;

    assign req_valid = MemRead | MemWrite;
    assign req_store = MemWrite & ~MemRead;

    // Lane placement for the incoming request; loads share the store byte-enable pattern.
    always_comb begin
        req_supported = 1'b0;
        case (Funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_supported = 1'b1;
            default:                                req_supported = 1'b0;
        endcase

        req_be    = 4'b1111;
        req_wdata = WriteData;
        case (Funct3[1:0])
            2'b00: begin
                req_be    = 4'b0001 << ALUResult[1:0];
                req_wdata = {4{WriteData[7:0]}};
            end
            2'b01: begin
                req_be    = 4'b0011 << {ALUResult[1], 1'b0};
                req_wdata = {2{WriteData[15:0]}};
            end
            default: begin
                req_be    = 4'b1111;
                req_wdata = WriteData;
            end
        endcase
        if (!req_store) begin
            req_wdata = '0;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned_q;

    assign req_misaligned = req_supported &&
                            (((Funct3[1:0] == 2'b01) && ALUResult[0]) ||
                             ((Funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00)));
    assign Misaligned     = misaligned_q;
`else
    assign req_misaligned = 1'b0;
    assign Misaligned     = 1'b0;
`endif

    function automatic logic [DATA_WIDTH-1:0] extend_load(
        input logic [FUNCT3_LENGTH-1:0] f3,
        input logic [1:0]               offset,
        input logic [DATA_WIDTH-1:0]    word
    );
        logic [7:0]            lane_b;
        logic [15:0]           lane_h;
        logic [DATA_WIDTH-1:0] result;
        lane_b = word[{offset, 3'b000} +: 8];
        lane_h = offset[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'b00:   result = f3[2] ? {{(DATA_WIDTH-8){1'b0}}, lane_b}
                                    : {{(DATA_WIDTH-8){lane_b[7]}}, lane_b};
            2'b01:   result = f3[2] ? {{(DATA_WIDTH-16){1'b0}}, lane_h}
                                    : {{(DATA_WIDTH-16){lane_h[15]}}, lane_h};
            default: result = word;
        endcase
        return result;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            funct3_q    <= '0;
            offset_q    <= '0;
            read_data_q <= '0;
            done_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        funct3_q    <= Funct3;
                        offset_q    <= ALUResult[1:0];
                        mem_we_q    <= req_store;
                        mem_addr_q  <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
                        mem_be_q    <= req_be;
                        mem_wdata_q <= req_wdata;
                        // Unsupported sizes and trapped misalignments finish without touching memory.
                        if (!req_supported || req_misaligned) begin
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            read_data_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                            misaligned_q <= req_misaligned;
`endif
                        end else begin
                            state_q   <= REQ;
                            mem_req_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        if (mem_we_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (mem_rvalid) begin
                            read_data_q <= extend_load(funct3_q, offset_q, mem_rdata);
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        read_data_q <= extend_load(funct3_q, offset_q, mem_rdata);
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
                    misaligned_q <= 1'b0;
`endif
                end
                default: begin
                    state_q   <= IDLE;
                    done_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign Stall     = ((state_q == IDLE) && req_valid) || (state_q == REQ) || (state_q == WAIT);
    assign ReadData  = read_data_q;
    assign Done      = done_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_unit.sv
`default_nettype none
// Testbench for lsu_unit: directed and randomized accesses, scoreboard against a behavioural model.
module tb_lsu_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult, WriteData;
    logic [31:0] ReadData;
    logic        Done, Stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        Misaligned;

    lsu_unit #(.DATA_WIDTH(32), .FUNCT3_LENGTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .Funct3(Funct3), .ALUResult(ALUResult), .WriteData(WriteData),
        .ReadData(ReadData), .Done(Done), .Stall(Stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .Misaligned(Misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          nomem;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rd;
        bit          mis;
    } exp_t;

    typedef struct {
        int          gd;
        int          rvd;
        logic [31:0] rdat;
        bit          ld;
    } rsp_t;

    exp_t        cq[$];
    rsp_t        rq[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_rd = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // Byte offset of the lowest enabled lane.
    function automatic int lane_base(input logic [2:0] f3, input logic [31:0] addr);
        int n;
        n = size_of(f3);
        if (n == 4) return 0;
        return (int'(addr % 4) / n) * n;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] w);
        longint unsigned m, v;
        int n;
        n = size_of(f3);
        m = (64'd1 << (8 * n)) - 1;
        v = (longint'(w) >> (8 * lane_base(f3, addr))) & m;
        if (f3 < 3'd4 && n < 4 && v >= (m + 1) / 2) v = v + (64'hFFFF_FFFF - m);
        return v[31:0];
    endfunction

    // Presents one request for a single cycle and records what must follow.
    task automatic present(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int gd, input int rvd,
                           input logic [31:0] rdat);
        exp_t ex;
        rsp_t r;
        bit   supported, mis;
        int   n;
        supported = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        n   = size_of(f3);
        mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = supported && ((n == 2 && addr[0]) || (n == 4 && (addr % 4) != 0));
`endif
        ex.nomem = !supported || mis;
        ex.we    = !ld;
        ex.addr  = addr - (addr % 4);
        ex.be    = 4'(((1 << n) - 1) << lane_base(f3, addr));
        if (n == 1)      ex.wdata = (wd & 32'hFF) * 32'h0101_0101;
        else if (n == 2) ex.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
        else             ex.wdata = wd;
        ex.mis = mis;
        if (ex.nomem)    ex.rd = 32'h0;
        else if (ld)     ex.rd = ref_load(f3, addr, rdat);
        else             ex.rd = last_rd;
        last_rd = ex.rd;
        cq.push_back(ex);
        if (!ex.nomem) begin
            r.gd = gd; r.rvd = rvd; r.rdat = rdat; r.ld = ld;
            rq.push_back(r);
        end
        MemRead   = ld;
        MemWrite  = ld ? 1'($urandom % 2) : 1'b1;
        Funct3    = f3;
        ALUResult = addr;
        WriteData = wd;
        @(posedge clk); #1;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Funct3    = 3'($urandom);
        ALUResult = $urandom;
        WriteData = $urandom;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (Done !== 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (Done !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: Done=%b after %0d cycles, required 1", Done, n);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
        @(posedge clk); #1;
    endtask

    task automatic run(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int gd, input int rvd,
                       input logic [31:0] rdat);
        present(ld, f3, addr, wd, gd, rvd, rdat);
        wait_done();
    endtask

    // Memory responder: grants/returns data per queued timing, injects stray pulses otherwise.
    initial begin : responder
        rsp_t r;
        int   st, c;
        st = 0; c = 0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (!rst_n) begin
                st = 0;
                rq.delete();
            end else if (st == 2) begin
                c--;
                if (c <= 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = r.rdat;
                    st = 0;
                end else begin
                    mem_gnt = ($urandom % 4 == 0);
                end
            end else begin
                if (st == 0 && mem_req && rq.size() > 0) begin
                    r  = rq.pop_front();
                    c  = r.gd;
                    st = 1;
                end
                if (st == 1) begin
                    if (c == 0) begin
                        mem_gnt = 1'b1;
                        if (r.ld && r.rvd == 0) begin
                            mem_rvalid = 1'b1;
                            mem_rdata  = r.rdat;
                            st = 0;
                        end else if (r.ld) begin
                            c  = r.rvd;
                            st = 2;
                        end else begin
                            st = 0;
                        end
                    end else begin
                        c--;
                    end
                end else begin
                    mem_gnt    = ($urandom % 4 == 0);
                    mem_rvalid = ($urandom % 4 == 0);
                end
            end
        end
    end

    // Monitor: follows each accepted access and compares port activity against the scoreboard.
    initial begin : monitor
        exp_t cur;
        bit   busy, granted, exp_done;
        busy = 0; granted = 0; exp_done = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cq.delete();
                busy = 0; granted = 0; exp_done = 0;
            end else begin
                if (Done || exp_done) chk("done_timing", 32'(Done), 32'(exp_done));
                exp_done = 0;
                if (Done) begin
                    if (cq.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL done_unexpected: Done=1 with no access outstanding, required 0");
                    end else begin
                        cur = cq.pop_front();
                        chk("read_data", ReadData, cur.rd);
                        chk("misaligned", 32'(Misaligned), 32'(cur.mis));
                    end
                    chk("stall_in_done", 32'(Stall), 32'h0);
                    chk("req_in_done", 32'(mem_req), 32'h0);
                    busy = 0;
                end else if (!busy) begin
                    chk("req_idle", 32'(mem_req), 32'h0);
                    if (MemRead || MemWrite) begin
                        chk("stall_accept", 32'(Stall), 32'h1);
                        if (cq.size() == 0) begin
                            tests++; fails++;
                            $display("FAIL accept_no_expect: request seen with empty scoreboard, required entry");
                        end else begin
                            cur = cq[0];
                            busy = 1; granted = 0;
                            if (cur.nomem) exp_done = 1;
                        end
                    end else begin
                        chk("stall_idle", 32'(Stall), 32'h0);
                    end
                end else begin
                    chk("stall_busy", 32'(Stall), 32'h1);
                    chk("mem_req", 32'(mem_req), 32'(!cur.nomem && !granted));
                    if (mem_req) begin
                        chk("mem_addr", mem_addr, cur.addr);
                        chk("mem_be", 32'(mem_be), 32'(cur.be));
                        chk("mem_we", 32'(mem_we), 32'(cur.we));
                        if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
                        if (mem_gnt) begin
                            granted = 1;
                            if (cur.we || mem_rvalid) exp_done = 1;
                        end
                    end else if (granted && !cur.we && mem_rvalid) begin
                        exp_done = 1;
                    end
                end
            end
        end
    end

    initial begin : driver
        bit          ld;
        logic [2:0]  f3;
        int          gap;
        rst_n = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'd0;
        ALUResult = 32'h0; WriteData = 32'h0;
        #3;
        chk("rst_ReadData", ReadData, 32'h0);
        chk("rst_Done", 32'(Done), 32'h0);
        chk("rst_Stall", 32'(Stall), 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_be", 32'(mem_be), 32'h0);
        chk("rst_Misaligned", 32'(Misaligned), 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run(1'b0, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 1, 0, 32'h0);
        run(1'b0, 3'b000, 32'h0000_2003, 32'h0000_00A5, 0, 0, 32'h0);
        run(1'b1, 3'b000, 32'h0000_3001, 32'h0,         0, 2, 32'h0000_8000);
        run(1'b1, 3'b100, 32'h0000_3001, 32'h0,         0, 2, 32'h0000_8000);
        run(1'b1, 3'b001, 32'h0000_3002, 32'h0,         0, 0, 32'h8001_1234);
        run(1'b0, 3'b011, 32'h0000_5000, 32'h1234_5678, 0, 0, 32'h0);
        run(1'b1, 3'b111, 32'h0000_5004, 32'h0,         0, 0, 32'h0);
        run(1'b1, 3'b010, 32'h0000_4002, 32'h0,         1, 1, 32'hCAFE_F00D);

        // Abandon a load in WAIT via reset.
        present(1'b1, 3'b010, 32'h0000_7008, 32'h0, 0, 8, 32'h1111_2222);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ReadData", ReadData, 32'h0);
        chk("midrst_Done", 32'(Done), 32'h0);
        chk("midrst_Stall", 32'(Stall), 32'h0);
        chk("midrst_mem_req", 32'(mem_req), 32'h0);
        chk("midrst_mem_we", 32'(mem_we), 32'h0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        chk("midrst_mem_be", 32'(mem_be), 32'h0);
        chk("midrst_mem_wdata", mem_wdata, 32'h0);
        chk("midrst_Misaligned", 32'(Misaligned), 32'h0);
        last_rd = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        run(1'b1, 3'b010, 32'h0000_6000, 32'h0, 1, 1, 32'h89AB_CDEF);

        for (int i = 0; i < 300; i++) begin
            ld = 1'($urandom % 2);
            f3 = 3'($urandom % 8);
            run(ld, f3, $urandom, $urandom, int'($urandom % 4), int'($urandom % 4), $urandom);
            gap = int'($urandom % 3);
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
- Load/store unit directly downstream of the ALU in the execute/memory path.
- Takes ALUResult as the effective address, plus store data and Funct3.
- Drives a word-wide memory port with a req/gnt/rvalid handshake, produces byte enables, and aligns stores into byte lanes.
- Returns sign- or zero-extended load data to writeback and stalls the pipeline while an access is outstanding.

Parameters:
- DATA_WIDTH, 32, data and address width; only 32 is supported.
- FUNCT3_LENGTH, 3, width of the Funct3 access-size field.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- MemRead  input  1  load request, qualified in IDLE.
- MemWrite  input  1  store request, qualified in IDLE. MemRead has priority if both are high.
- Funct3  input  3  access size and signedness: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ALUResult  input  32  effective byte address.
- WriteData  input  32  store data, right-justified.
- ReadData  output  32  extended load result; valid while Done=1.
- Done  output  1  one-cycle completion pulse.
- Stall  output  1  high while an access is in flight.
- mem_req  output  1  memory request.
- mem_we  output  1  1=write, 0=read.
- mem_addr  output  32  word-aligned address: {addr[31:2],2'b00}.
- mem_be  output  4  byte enables.
- mem_wdata  output  32  lane-aligned store data.
- mem_gnt  input  1  request accepted.
- mem_rvalid  input  1  read data valid.
- mem_rdata  input  32  read word.
- Misaligned  output  1  see Optional Feature; tied 0 when the feature is compiled out.

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE.
  - All outputs 0: ReadData, Done, Stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata, Misaligned.
  - Reset mid-access abandons the transaction; no Done is issued.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On MemRead|MemWrite, latch address, Funct3, WriteData and direction.
  - Go to REQ, or to DONE for an unsupported Funct3 (011, 110, 111): no memory access, ReadData=0.
- REQ:
  - mem_req=1, with mem_addr, mem_be, mem_wdata, mem_we held stable until mem_gnt.
  - On mem_gnt: a store goes to DONE; a load goes to WAIT.
  - mem_req drops in the cycle after the grant.
- WAIT:
  - mem_req=0; hold until mem_rvalid.
  - On mem_rvalid, capture and extend mem_rdata into ReadData, then go to DONE.
  - mem_rvalid in the same cycle as mem_gnt is legal: REQ goes straight to DONE with the data captured.
- DONE: Done=1 for exactly one cycle, then IDLE. A new request is accepted only in IDLE, never in DONE.
- Stall is combinational:
  - 1 when (IDLE and MemRead|MemWrite) or state is REQ or WAIT.
  - 0 in DONE.
- Byte lanes, where a=addr[1:0]:
  - B: mem_be = 4'b0001<<a; mem_wdata = {4{WriteData[7:0]}}.
  - H: mem_be = 4'b0011<<{a[1],1'b0}; mem_wdata = {2{WriteData[15:0]}}.
  - W: mem_be = 4'b1111; mem_wdata = WriteData.
  - Loads drive the same mem_be pattern.
- Load extraction:
  - Byte taken from mem_rdata[8a+7:8a]; halfword from lane a[1].
  - B and H sign-extend; BU and HU zero-extend.
  - ReadData holds its value until the next load completes.
- Back-to-back accesses: minimum 3 cycles per store (IDLE→REQ→DONE) with zero-wait gnt.
- Unexpected inputs: mem_gnt outside REQ and mem_rvalid outside REQ/WAIT are ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - An H/HU access with a[0]=1, or a W access with a≠0, skips memory and goes IDLE→DONE.
  - Misaligned=1 together with Done; ReadData=0; no mem_req is issued.
- Undefined:
  - Misaligned is tied 0.
  - For H the offending low address bit is ignored (lane chosen by a[1]); for W the low bits are ignored.

Test Plan:
- SW addr 0x1004, WriteData 0xDEADBEEF, gnt on the 2nd REQ cycle -> mem_addr 0x1004, mem_be 1111, mem_wdata 0xDEADBEEF, mem_we 1, Done one cycle after gnt, Stall high until then.
- SB addr 0x2003, WriteData 0x000000A5 -> mem_be 1000, mem_wdata 0xA5A5A5A5, mem_addr 0x2000.
- LB addr 0x3001, mem_rdata 0x0000_80_00, rvalid 2 cycles after gnt -> ReadData 0xFFFFFF80; LBU with the same data -> 0x00000080.
- LH addr 0x3002, mem_rdata 0x8001_1234, gnt and rvalid in the same cycle -> ReadData 0xFFFF8001, Done the next cycle.
- Assert rst_n=0 while in WAIT, then release -> all outputs 0, no Done; a following LW completes normally.
- With LSU_MISALIGN_TRAP_EN, LW addr 0x4002 -> no mem_req, Done=1 with Misaligned=1; without the macro -> mem_addr 0x4000, normal load.
